regfile_rr_arbiter: RTL and testbench

- Shares one small register bank (DEPTH words of WIDTH-bit D-type storage) among NREQ requesters.
- Each requester issues a read or write over a req/ack handshake; the block grants one requester at a time in round-robin order.
- Sits between the control units and the shared storage; it is the only writer of that storage.

---
 rtl/regfile_rr_arbiter_pkg.sv | 24 ++
 rtl/regfile_rr_arbiter_chk.sv | 17 +
 rtl/regfile_rr_arbiter_pick.sv | 42 ++++
 rtl/regfile_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_rr_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_rr_arbiter_pkg.sv
// Shared definitions for the round-robin register-bank arbiter:
// FSM state encoding, default geometry and a modulo-increment helper.
package regfile_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_AW    = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } arb_state_e;

    // Returns (idx + 1) mod n without needing a divider.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/regfile_rr_arbiter_chk.sv
// Invariant checker for the arbiter outputs; carries no design state.
module regfile_rr_arbiter_chk #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            reset,
    input logic [NREQ-1:0] gnt,
    input logic [NREQ-1:0] ack,
    input logic            busy
);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(ack));
    a_ack_in_gnt: assert property (@(posedge clk) disable iff (reset) (ack & ~gnt) == {NREQ{1'b0}});
    a_busy_gnt:   assert property (@(posedge clk) disable iff (reset) busy == (|gnt));

endmodule

// File: rtl/regfile_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ.
module rr_priority_pick
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [PW-1:0]   pick_idx,
    output logic            any
);

    logic [NREQ-1:0] pick_s;
    logic [PW-1:0]   idx_s;
    logic            any_s;
    logic [PW-1:0]   cand_s;
    logic            hit_s;

    // Scan candidates in rotated order; the first hit wins.
    always_comb begin
        pick_s = {NREQ{1'b0}};
        idx_s  = {PW{1'b0}};
        any_s  = 1'b0;
        cand_s = {PW{1'b0}};
        hit_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = PW'((int'(ptr) + k) % NREQ);
            hit_s  = !any_s && req[cand_s];
            any_s  = any_s | hit_s;
            pick_s = pick_s | (NREQ'(hit_s) << cand_s);
            idx_s  = hit_s ? cand_s : idx_s;
        end
    end

    assign pick     = pick_s;
    assign pick_idx = idx_s;
    assign any      = any_s;

endmodule

// File: rtl/regfile_rr_arbiter.sv
// Round-robin arbiter granting NREQ requesters exclusive single-access
// use of a small shared register bank.
module regfile_rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4,
    parameter int AW    = DEF_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       wr,
    input  logic [NREQ*AW-1:0]    addr,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);

    arb_state_e       state_r;
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    g_idx_r;
    logic [NREQ-1:0]  gnt_r;
    logic [NREQ-1:0]  ack_r;
    logic [WIDTH-1:0] rdata_r;
    logic             busy_r;
    logic [WIDTH-1:0] bank_r [DEPTH];

    logic [NREQ-1:0]  pick_s;
    logic [PW-1:0]    pick_idx_s;
    logic             any_s;
    logic [PW-1:0]    ptr_next_s;
    logic [AW-1:0]    g_addr_s;
    logic [WIDTH-1:0] g_wdata_s;
    logic             g_wr_s;
    logic             g_req_s;

    rr_priority_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req      (req),
        .ptr      (ptr_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .any      (any_s)
    );

    // Route the granted requester's command fields and compute the next pointer.
    always_comb begin
        g_addr_s   = addr[int'(g_idx_r)*AW +: AW];
        g_wdata_s  = wdata[int'(g_idx_r)*WIDTH +: WIDTH];
        g_wr_s     = wr[g_idx_r];
        g_req_s    = req[g_idx_r];
        ptr_next_s = PW'(wrap_inc(32'(pick_idx_s), 32'(NREQ)));
    end

    // Arbitration FSM and bank storage; reset wins over any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= {PW{1'b0}};
            g_idx_r <= {PW{1'b0}};
            gnt_r   <= {NREQ{1'b0}};
            ack_r   <= {NREQ{1'b0}};
            rdata_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= {NREQ{1'b0}};
                    if (any_s) begin
                        gnt_r   <= pick_s;
                        g_idx_r <= pick_idx_s;
                        ptr_r   <= ptr_next_s;
                        state_r <= ST_ACCESS;
                        busy_r  <= 1'b1;
                    end else begin
                        gnt_r   <= {NREQ{1'b0}};
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (g_wr_s) begin
                        bank_r[g_addr_s] <= g_wdata_s;
                    end else begin
                        rdata_r <= bank_r[g_addr_s];
                    end
                    ack_r   <= gnt_r;
                    state_r <= ST_HOLD;
                    busy_r  <= 1'b1;
                end
                ST_HOLD: begin
                    // No second access until the owner has released its request.
                    ack_r <= {NREQ{1'b0}};
                    if (!g_req_s) begin
                        gnt_r   <= {NREQ{1'b0}};
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    gnt_r   <= {NREQ{1'b0}};
                    ack_r   <= {NREQ{1'b0}};
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_r;
    assign ack   = ack_r;
    assign rdata = rdata_r;
    assign busy  = busy_r;

    regfile_rr_arbiter_chk #(
        .NREQ (NREQ)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .gnt   (gnt_r),
        .ack   (ack_r),
        .busy  (busy_r)
    );

endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// Randomized bench for regfile_rr_arbiter against a transaction-level model
// (memory array plus round-robin pointer).
module tb_regfile_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       wr;
    logic [NREQ*AW-1:0]    addr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      rdata;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mem_m [DEPTH];
    logic [WIDTH-1:0] rd_m;
    int               ptr_m;
    int               won;

    regfile_rr_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .rdata (rdata),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic raise(input int i, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req[i]               = 1'b1;
        wr[i]                = w;
        addr[i*AW +: AW]     = a;
        wdata[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        rd_m  = '0;
        ptr_m = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One full grant/ack/release cycle; the owner keeps req for 'hold' extra cycles.
    task automatic do_txn(input int hold, output int winner);
        int               pick;
        logic [NREQ-1:0]  oh;
        logic             is_wr;
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        pick = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (pick < 0 && req[(ptr_m + k) % NREQ]) pick = (ptr_m + k) % NREQ;
        end
        winner = pick;
        if (pick < 0) return;
        oh    = NREQ'(1) << pick;
        is_wr = wr[pick];
        a     = addr[pick*AW +: AW];
        d     = wdata[pick*WIDTH +: WIDTH];
        ptr_m = (pick + 1) % NREQ;

        @(negedge clk);
        check_val("gnt_e0", 32'(gnt), 32'(oh));
        check_val("ack_e0", 32'(ack), 32'(0));
        check_val("busy_e0", 32'(busy), 32'(1));
        check_val("rdata_hold", 32'(rdata), 32'(rd_m));

        @(negedge clk);
        check_val("ack_e1", 32'(ack), 32'(oh));
        check_val("gnt_e1", 32'(gnt), 32'(oh));
        if (is_wr) begin
            mem_m[a] = d;
            check_val("rdata_wr", 32'(rdata), 32'(rd_m));
        end else begin
            rd_m = mem_m[a];
            check_val("rdata_rd", 32'(rdata), 32'(rd_m));
        end

        if (is_wr) wdata[pick*WIDTH +: WIDTH] = ~d;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("hold_ack", 32'(ack), 32'(0));
            check_val("hold_gnt", 32'(gnt), 32'(oh));
            check_val("hold_busy", 32'(busy), 32'(1));
        end

        req[pick] = 1'b0;
        @(negedge clk);
        check_val("rel_gnt", 32'(gnt), 32'(0));
        check_val("rel_ack", 32'(ack), 32'(0));
        check_val("rel_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b1;
        req   = 4'hF;
        wr    = '0;
        addr  = '0;
        wdata = '0;
        model_reset();
        @(negedge clk);
        check_val("rst_gnt", 32'(gnt), 32'(0));
        check_val("rst_ack", 32'(ack), 32'(0));
        check_val("rst_rdata", 32'(rdata), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        req   = '0;

        for (int a = 0; a < DEPTH; a++) begin
            raise(0, 1'b0, AW'(a), 8'h00);
            do_txn(0, won);
        end

        raise(0, 1'b1, 2'd2, 8'hA5);
        do_txn(0, won);
        raise(0, 1'b0, 2'd2, 8'h00);
        do_txn(0, won);
        check_val("raw_a5", 32'(rdata), 32'h0000_00A5);

        // Everyone requesting: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NREQ; i++) raise(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        for (int n = 0; n < 5; n++) begin
            do_txn(0, won);
            check_val("rr_order", 32'(won), 32'(n % NREQ));
            raise(won, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end

        req = '0;
        raise(3, 1'b0, 2'd0, 8'h00);
        do_txn(0, won);
        check_val("wrap_g3", 32'(won), 32'(3));
        raise(0, 1'b0, 2'd1, 8'h00);
        raise(2, 1'b0, 2'd3, 8'h00);
        do_txn(0, won);
        check_val("wrap_g0", 32'(won), 32'(0));
        do_txn(0, won);
        check_val("wrap_g2", 32'(won), 32'(2));

        req = '0;
        raise(1, 1'b1, 2'd3, 8'h5A);
        do_txn(5, won);
        raise(1, 1'b0, 2'd3, 8'h00);
        do_txn(0, won);
        check_val("hold_once", 32'(rdata), 32'h0000_005A);

        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) != 0)
                    raise(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            end
            if (req == '0) raise(int'($urandom_range(0, 3)), 1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            do_txn(int'($urandom_range(0, 2)), won);
        end

        // Reset lands on the ACCESS edge of a write; the write must not commit.
        req = '0;
        @(negedge clk);
        raise(0, 1'b1, 2'd1, 8'h3C);
        @(negedge clk);
        check_val("mid_gnt_pre", 32'(gnt), 32'(1));
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_val("mid_gnt", 32'(gnt), 32'(0));
        check_val("mid_ack", 32'(ack), 32'(0));
        check_val("mid_busy", 32'(busy), 32'(0));
        check_val("mid_rdata", 32'(rdata), 32'(0));
        raise(0, 1'b0, 2'd1, 8'h00);
        do_txn(0, won);
        check_val("mid_nocommit", 32'(rdata), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
